// File: rtl/sha256_nonce_scheduler.sv
// -----------------------------------------------------------------------------
// sha256_nonce_scheduler
//
// Purpose:
//   Walks a nonce range for a Bitcoin-style double SHA256 and drives an
//   external single-block SHA256 compression core. For every nonce, it runs
//   two compressions:
//     1. The header tail block, chained from the job midstate.
//     2. The padded 32-byte first digest, chained from the SHA256 IV.
//   It then compares the byte-reversed second digest against the job target.
//   Winning nonces are presented on a held found_valid/found_ack handshake.
//
// Ports:
//   clock, reset_n           - rising-edge clock, asynchronous active-low reset
//   job_valid / job_ready    - job offer; accepted when both are high
//   job_midstate/tail/target - job data, registered at accept
//   nonce_start / nonce_end  - inclusive nonce range, registered at accept
//   abort                    - cancel the running job (ignored in IDLE)
//   core_start               - one-cycle launch pulse to the SHA256 core
//   core_block/core_hash_in  - message block and chaining value to the core
//   core_done/core_hash_out  - one-cycle completion pulse with result
//   found_valid/found_nonce  - winning nonce, held until found_ack
//   found_ack                - consumer accepts found_nonce (FOUND only)
//   busy                     - scheduler is not IDLE
//   exhausted                - one-cycle pulse when the range is finished/empty
//   hashes_done              - nonces fully checked since job accept
//   dbg_state                - current FSM state encoding, for observation
//
// Handshakes:
//   A transfer happens on a rising edge where valid and ready are both high.
//   For the job port, ready is high only in IDLE. For the found port,
//   found_valid is held with a stable found_nonce until found_ack is sampled.
// -----------------------------------------------------------------------------
module sha256_nonce_scheduler #(
    parameter int COUNT_W = 32
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               job_valid,
    output logic               job_ready,
    input  logic [255:0]       job_midstate,
    input  logic [95:0]        job_tail,
    input  logic [255:0]       job_target,
    input  logic [31:0]        nonce_start,
    input  logic [31:0]        nonce_end,
    input  logic               abort,
    output logic               core_start,
    output logic [511:0]       core_block,
    output logic [255:0]       core_hash_in,
    input  logic               core_done,
    input  logic [255:0]       core_hash_out,
    output logic               found_valid,
    output logic [31:0]        found_nonce,
    input  logic               found_ack,
    output logic               busy,
    output logic               exhausted,
    output logic [COUNT_W-1:0] hashes_done,
    output logic [2:0]         dbg_state
);

    localparam logic [255:0] SHA256_IV =
        256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_H1    = 3'd1,
        S_W1    = 3'd2,
        S_H2    = 3'd3,
        S_W2    = 3'd4,
        S_CHECK = 3'd5,
        S_FOUND = 3'd6,
        S_DRAIN = 3'd7
    } state_e;

    state_e             state_q, state_d;
    logic [255:0]       midstate_q, midstate_d;
    logic [95:0]        tail_q, tail_d;
    logic [255:0]       target_q, target_d;
    logic [31:0]        nonce_q, nonce_d;
    logic [31:0]        end_q, end_d;
    logic [255:0]       digest1_q, digest1_d;
    logic [255:0]       digest2_q, digest2_d;
    logic [COUNT_W-1:0] hashes_q, hashes_d;
    logic [31:0]        found_nonce_q, found_nonce_d;
    logic               exhausted_q, exhausted_d;

    logic [255:0]       digest_rev;
    logic               hit;
    logic               last_nonce;
    logic [511:0]       block1;
    logic [511:0]       block2;

    // The first block carries the 12-byte header tail, the nonce, and padding.
    // Its length field is 640 bits, the full 80-byte header.
    assign block1 = {tail_q, nonce_q, 1'b1, 319'b0, 64'd640};
    // The second block hashes the 32-byte first digest with padding.
    assign block2 = {digest1_q, 1'b1, 191'b0, 64'd256};

    // The target is compared against the digest read as a little-endian number:
    // the last digest byte becomes the most significant byte.
    always_comb begin
        digest_rev = '0;
        for (int i = 0; i < 32; i++) begin
            digest_rev[8*i +: 8] = digest2_q[8*(31-i) +: 8];
        end
    end

    assign hit        = (digest_rev <= target_q);
    // The range ends by equality with nonce_end, so an end of FFFFFFFF never wraps.
    assign last_nonce = (nonce_q == end_q);

    // Next-state logic
    always_comb begin
        state_d       = state_q;
        midstate_d    = midstate_q;
        tail_d        = tail_q;
        target_d      = target_q;
        nonce_d       = nonce_q;
        end_d         = end_q;
        digest1_d     = digest1_q;
        digest2_d     = digest2_q;
        hashes_d      = hashes_q;
        found_nonce_d = found_nonce_q;
        exhausted_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (job_valid) begin
                    midstate_d = job_midstate;
                    tail_d     = job_tail;
                    target_d   = job_target;
                    nonce_d    = nonce_start;
                    end_d      = nonce_end;
                    hashes_d   = '0;
                    if (nonce_start > nonce_end) begin
                        exhausted_d = 1'b1;
                    end else begin
                        state_d = S_H1;
                    end
                end
            end
            S_H1: begin
                state_d = abort ? S_IDLE : S_W1;
            end
            S_W1: begin
                // A completion arriving together with the abort means that
                // nothing is left outstanding, so DRAIN can be skipped.
                if (abort) begin
                    state_d = core_done ? S_IDLE : S_DRAIN;
                end else if (core_done) begin
                    digest1_d = core_hash_out;
                    state_d   = S_H2;
                end
            end
            S_H2: begin
                state_d = abort ? S_IDLE : S_W2;
            end
            S_W2: begin
                if (abort) begin
                    state_d = core_done ? S_IDLE : S_DRAIN;
                end else if (core_done) begin
                    digest2_d = core_hash_out;
                    state_d   = S_CHECK;
                end
            end
            S_CHECK: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else begin
                    hashes_d = hashes_q + COUNT_W'(1);
                    if (hit) begin
                        found_nonce_d = nonce_q;
                        state_d       = S_FOUND;
                    end else if (last_nonce) begin
                        exhausted_d = 1'b1;
                        state_d     = S_IDLE;
                    end else begin
                        nonce_d = nonce_q + 32'd1;
                        state_d = S_H1;
                    end
                end
            end
            S_FOUND: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (found_ack) begin
                    if (last_nonce) begin
                        exhausted_d = 1'b1;
                        state_d     = S_IDLE;
                    end else begin
                        nonce_d = nonce_q + 32'd1;
                        state_d = S_H1;
                    end
                end
            end
            S_DRAIN: begin
                if (core_done) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            midstate_q    <= '0;
            tail_q        <= '0;
            target_q      <= '0;
            nonce_q       <= '0;
            end_q         <= '0;
            digest1_q     <= '0;
            digest2_q     <= '0;
            hashes_q      <= '0;
            found_nonce_q <= '0;
            exhausted_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            midstate_q    <= midstate_d;
            tail_q        <= tail_d;
            target_q      <= target_d;
            nonce_q       <= nonce_d;
            end_q         <= end_d;
            digest1_q     <= digest1_d;
            digest2_q     <= digest2_d;
            hashes_q      <= hashes_d;
            found_nonce_q <= found_nonce_d;
            exhausted_q   <= exhausted_d;
        end
    end

    // Core-facing outputs
    // core_start is gated by abort so that an aborted launch never leaves an
    // untracked compression running in the core.
    always_comb begin
        core_start   = 1'b0;
        core_block   = '0;
        core_hash_in = '0;
        case (state_q)
            S_H1: begin
                core_start   = !abort;
                core_block   = block1;
                core_hash_in = midstate_q;
            end
            S_W1: begin
                core_block   = block1;
                core_hash_in = midstate_q;
            end
            S_H2: begin
                core_start   = !abort;
                core_block   = block2;
                core_hash_in = SHA256_IV;
            end
            S_W2: begin
                core_block   = block2;
                core_hash_in = SHA256_IV;
            end
            default: begin
                core_start   = 1'b0;
            end
        endcase
    end

    assign job_ready   = (state_q == S_IDLE);
    assign busy        = (state_q != S_IDLE);
    assign found_valid = (state_q == S_FOUND);
    assign found_nonce = found_nonce_q;
    assign exhausted   = exhausted_q;
    assign hashes_done = hashes_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_sha256_nonce_scheduler.sv
module tb_sha256_nonce_scheduler;
  localparam logic [255:0] IV =
    256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [255:0] ONES = {256{1'b1}};

  // ---------------- clock / reset / DUT ----------------
  logic         clock = 1'b0;
  logic         reset_n;
  logic         job_valid, job_ready, abort, core_start, core_done;
  logic         found_valid, found_ack, busy, exhausted;
  logic [255:0] job_midstate, job_target, core_hash_in, core_hash_out;
  logic [95:0]  job_tail;
  logic [31:0]  nonce_start, nonce_end, found_nonce, hashes_done;
  logic [511:0] core_block;
  logic [2:0]   dbg_state;

  always #5 clock = ~clock;

  sha256_nonce_scheduler #(.COUNT_W(32)) dut (
    .clock(clock), .reset_n(reset_n),
    .job_valid(job_valid), .job_ready(job_ready),
    .job_midstate(job_midstate), .job_tail(job_tail), .job_target(job_target),
    .nonce_start(nonce_start), .nonce_end(nonce_end), .abort(abort),
    .core_start(core_start), .core_block(core_block), .core_hash_in(core_hash_in),
    .core_done(core_done), .core_hash_out(core_hash_out),
    .found_valid(found_valid), .found_nonce(found_nonce), .found_ack(found_ack),
    .busy(busy), .exhausted(exhausted), .hashes_done(hashes_done),
    .dbg_state(dbg_state)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural core + reference model ----------------
  // Stand-in compression function: any deterministic mixing suffices for
  // the scheduler; nonce bits are folded into the low bytes so hits vary.
  function automatic logic [255:0] core_f(input logic [255:0] h, input logic [511:0] b);
    logic [255:0] x;
    x = h ^ b[511:256] ^ b[255:0];
    x = x ^ (x >> 128);
    x = x ^ (x >> 64);
    x = x ^ (x >> 32);
    x = x * 256'h9e3779b97f4a7c15f39cc0605cedc835;
    x = x ^ (x >> 96);
    return x;
  endfunction

  function automatic logic [255:0] byte_rev(input logic [255:0] d);
    logic [255:0] r;
    for (int i = 0; i < 32; i++) r[255 - 8*i -: 8] = d[8*i +: 8];
    return r;
  endfunction

  function automatic logic [511:0] blk1(input logic [95:0] tail, input logic [31:0] n);
    return {tail, n, 1'b1, 319'b0, 64'd640};
  endfunction

  function automatic logic [511:0] blk2(input logic [255:0] d1);
    return {d1, 1'b1, 191'b0, 64'd256};
  endfunction

  logic [31:0] exp_q[$];

  // Fills exp_q with every winning nonce of the range, in order.
  task automatic model_job(input logic [255:0] mid, input logic [95:0] tail,
                           input logic [255:0] tgt, input logic [31:0] s,
                           input logic [31:0] e, output int n_hash);
    logic [255:0] d1, d2;
    logic [31:0]  n32;
    n_hash = 0;
    for (longint n = longint'(s); n <= longint'(e); n++) begin
      n32 = n[31:0];
      d1 = core_f(mid, blk1(tail, n32));
      d2 = core_f(IV, blk2(d1));
      n_hash++;
      if (byte_rev(d2) <= tgt) exp_q.push_back(n32);
    end
  endtask

  typedef struct {
    int           c;
    logic [255:0] h;
    logic [511:0] b;
  } launch_t;

  launch_t      launches[$];
  int           done_cyc[$];
  int           cyc = 0;
  int           lat = 4;
  int           start_cnt = 0;
  int           overlap_viol = 0;
  int           cnt = 0;
  logic [255:0] pend_h;
  logic [511:0] pend_b;

  always @(posedge clock) cyc <= cyc + 1;

  // External core: samples core_start mid-cycle and answers lat cycles later.
  always @(negedge clock) begin
    core_done = 1'b0;
    if (cnt > 0) begin
      cnt--;
      if (cnt == 0) begin
        core_done     = 1'b1;
        core_hash_out = core_f(pend_h, pend_b);
        done_cyc.push_back(cyc);
      end
    end
    if (core_start) begin
      start_cnt++;
      if (cnt != 0) overlap_viol++;
      launches.push_back('{cyc, core_hash_in, core_block});
      cnt    = lat;
      pend_h = core_hash_in;
      pend_b = core_block;
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic [255:0] rand256();
    return {$urandom(), $urandom(), $urandom(), $urandom(),
            $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic drive_job(input logic [255:0] mid, input logic [95:0] tail,
                           input logic [255:0] tgt, input logic [31:0] s,
                           input logic [31:0] e);
    job_valid    = 1'b1;
    job_midstate = mid;
    job_tail     = tail;
    job_target   = tgt;
    nonce_start  = s;
    nonce_end    = e;
  endtask

  // Runs one job to completion, acking every found with a random delay and
  // comparing each found nonce against the model's expected queue.
  task automatic run_job(input logic [255:0] mid, input logic [95:0] tail,
                         input logic [255:0] tgt, input logic [31:0] s,
                         input logic [31:0] e, input int l, input string tag,
                         output int n_found, output int n_ex, output int hashes,
                         output int starts, output int acc_cyc,
                         output int exp_found, output int exp_hash);
    int   s0, wt;
    bit   seen, fin;
    logic [31:0] held;
    n_found = 0; n_ex = 0; wt = 0; seen = 0; fin = 0; held = '0;
    @(negedge clock);
    lat = l;
    launches.delete();
    done_cyc.delete();
    exp_q.delete();
    model_job(mid, tail, tgt, s, e, exp_hash);
    exp_found = exp_q.size();
    s0 = start_cnt;
    acc_cyc = cyc;
    drive_job(mid, tail, tgt, s, e);
    @(negedge clock);
    job_valid = 1'b0;
    for (int k = 0; k < 3000 && !fin; k++) begin
      found_ack = 1'b0;
      if (exhausted) n_ex++;
      if (found_valid) begin
        if (!seen) begin
          seen = 1; n_found++; held = found_nonce;
          if (exp_q.size() == 0) check({tag, " unexpected found"}, found_nonce, 512'd0 - 1);
          else check({tag, " found_nonce"}, found_nonce, exp_q.pop_front());
          wt = $urandom_range(0, 2);
        end else begin
          check({tag, " found_nonce held"}, found_nonce, held);
        end
        if (wt == 0) begin found_ack = 1'b1; seen = 0; end
        else wt--;
      end
      if (!busy && n_ex > 0) fin = 1;
      else @(negedge clock);
    end
    found_ack = 1'b0;
    checks++;
    if (!fin) begin
      errors++;
      $display("FAIL %s timeout: job did not finish within cycle budget", tag);
    end
    repeat (3) begin
      @(negedge clock);
      if (exhausted) n_ex++;
    end
    hashes = hashes_done;
    starts = start_cnt - s0;
    check({tag, " expected founds left"}, exp_q.size(), 0);
  endtask

  typedef struct {
    logic [31:0]  s;
    logic [31:0]  e;
    logic [255:0] tgt;
    int           exp_hashes;
    int           exp_found;
    int           exp_starts;
  } vec_t;

  // ---------------- main sequence ----------------
  initial begin
    vec_t         vecs[4];
    int           nf, nx, hs, st, ac, ef, eh, s0, c0, busy_cycles, bad;
    logic [255:0] mid, tgt, d1;
    logic [95:0]  tail;
    logic [31:0]  s, e;
    bit           fin;

    vecs[0] = '{s: 32'd5,          e: 32'd7,          tgt: ONES,    exp_hashes: 3, exp_found: 3, exp_starts: 6};
    vecs[1] = '{s: 32'd0,          e: 32'd3,          tgt: 256'd0,  exp_hashes: 4, exp_found: 0, exp_starts: 8};
    vecs[2] = '{s: 32'hFFFFFFFE,   e: 32'hFFFFFFFF,   tgt: ONES,    exp_hashes: 2, exp_found: 2, exp_starts: 4};
    vecs[3] = '{s: 32'd10,         e: 32'd9,          tgt: ONES,    exp_hashes: 0, exp_found: 0, exp_starts: 0};

    reset_n = 1'b0;
    job_valid = 0; abort = 0; found_ack = 0;
    job_midstate = '0; job_tail = '0; job_target = '0; nonce_start = '0; nonce_end = '0;
    core_done = 0; core_hash_out = '0;
    repeat (2) @(negedge clock);
    check("reset job_ready", job_ready, 1);
    check("reset busy", busy, 0);
    check("reset core_start", core_start, 0);
    check("reset found_valid", found_valid, 0);
    check("reset exhausted", exhausted, 0);
    check("reset hashes_done", hashes_done, 0);
    check("reset core_block", core_block, 0);
    reset_n = 1'b1;
    @(negedge clock);

    // Table-driven range jobs
    for (int i = 0; i < 4; i++) begin
      mid = rand256(); tail = rand256();
      run_job(mid, tail, vecs[i].tgt, vecs[i].s, vecs[i].e, 4, $sformatf("vec%0d", i),
              nf, nx, hs, st, ac, ef, eh);
      check($sformatf("vec%0d found count", i), nf, vecs[i].exp_found);
      check($sformatf("vec%0d model found count", i), ef, vecs[i].exp_found);
      check($sformatf("vec%0d hashes_done", i), hs, vecs[i].exp_hashes);
      check($sformatf("vec%0d core_start count", i), st, vecs[i].exp_starts);
      check($sformatf("vec%0d exhausted pulses", i), nx, 1);
    end

    // Reset while W1 is waiting on the core; found_nonce still holds 32'hFFFFFFFF
    @(negedge clock);
    lat = 4; s0 = start_cnt;
    drive_job(rand256(), rand256(), 256'd0, 32'd20, 32'd30);
    @(negedge clock); job_valid = 1'b0;
    @(negedge clock);
    check("pre-reset in W1 busy", busy, 1);
    reset_n = 1'b0;
    #1;
    check("reset W1 job_ready", job_ready, 1);
    check("reset W1 busy", busy, 0);
    check("reset W1 core_start", core_start, 0);
    check("reset W1 found_valid", found_valid, 0);
    check("reset W1 found_nonce", found_nonce, 0);
    check("reset W1 exhausted", exhausted, 0);
    check("reset W1 hashes_done", hashes_done, 0);
    check("reset W1 core_block", core_block, 0);
    check("reset W1 core_hash_in", core_hash_in, 0);
    @(negedge clock); reset_n = 1'b1;
    bad = 0;
    repeat (8) begin
      @(negedge clock);
      if (busy || exhausted || found_valid) bad++;
    end
    check("late core_done after reset ignored", bad, 0);
    check("no core_start after reset", start_cnt - s0, 1);

    // Exact encoding and latency of the two compressions per nonce
    mid = rand256(); tail = rand256();
    run_job(mid, tail, 256'd0, 32'h12345678, 32'h12345679, 4, "blk", nf, nx, hs, st, ac, ef, eh);
    checks++;
    if (launches.size() != 4 || done_cyc.size() < 2) begin
      errors++;
      $display("FAIL blk launch log: got %0d launches expected 4", launches.size());
    end else begin
      d1 = core_f(mid, blk1(tail, 32'h12345678));
      check("blk first start latency", launches[0].c - ac, 1);
      check("blk first hash_in", launches[0].h, mid);
      check("blk first block", launches[0].b, {tail, 32'h12345678, 1'b1, 319'b0, 64'h280});
      check("blk second hash_in", launches[1].h, IV);
      check("blk second block", launches[1].b, {d1, 1'b1, 191'b0, 64'h100});
      check("blk done->H2 start gap", launches[1].c - done_cyc[0], 1);
      check("blk done->next H1 start gap", launches[2].c - done_cyc[1], 2);
      check("blk next nonce block", launches[2].b, blk1(tail, 32'h12345679));
    end

    // Empty range: exhausted exactly in cycle 1 after accept, with no launch
    @(negedge clock);
    s0 = start_cnt;
    drive_job(rand256(), rand256(), ONES, 32'd10, 32'd9);
    @(negedge clock); job_valid = 1'b0;
    check("empty exhausted cycle1", exhausted, 1);
    check("empty busy", busy, 0);
    @(negedge clock);
    check("empty exhausted single", exhausted, 0);
    check("empty no core_start", start_cnt - s0, 0);

    // Abort in W1: DRAIN until the outstanding core_done, then IDLE
    @(negedge clock);
    lat = 4; s0 = start_cnt; c0 = cyc;
    drive_job(rand256(), rand256(), ONES, 32'd100, 32'd200);
    @(negedge clock); job_valid = 1'b0;
    @(negedge clock); abort = 1'b1;
    @(negedge clock); abort = 1'b0;
    busy_cycles = 0; bad = 0; fin = 0;
    for (int k = 0; k < 20 && !fin; k++) begin
      if (!busy) fin = 1;
      else begin
        busy_cycles++;
        if (found_valid || exhausted) bad++;
        @(negedge clock);
      end
    end
    check("drain exit cycle", cyc - c0, 1 + 4 + 1);
    check("drain busy cycles", busy_cycles, 3);
    repeat (3) begin
      @(negedge clock);
      if (found_valid || exhausted || busy) bad++;
    end
    check("drain no found/exhausted", bad, 0);
    check("drain single launch", start_cnt - s0, 1);

    // Abort coinciding with core_done in W1 goes straight to IDLE
    @(negedge clock);
    lat = 4; s0 = start_cnt; c0 = cyc;
    drive_job(rand256(), rand256(), ONES, 32'd1, 32'd9);
    @(negedge clock); job_valid = 1'b0;
    for (int k = 0; k < 10 && cyc < c0 + 5; k++) @(negedge clock);
    abort = 1'b1;
    @(negedge clock); abort = 1'b0;
    check("abort+done busy", busy, 0);
    repeat (4) @(negedge clock);
    check("abort+done stays idle", busy, 0);
    check("abort+done single launch", start_cnt - s0, 1);

    // abort held from IDLE into H1: accept still happens, launch suppressed
    @(negedge clock);
    s0 = start_cnt; bad = 0;
    drive_job(rand256(), rand256(), ONES, 32'd50, 32'd60);
    abort = 1'b1;
    @(negedge clock); job_valid = 1'b0;
    check("abort in H1 busy", busy, 1);
    @(negedge clock); abort = 1'b0;
    check("abort in H1 back to idle", busy, 0);
    repeat (3) begin
      @(negedge clock);
      if (exhausted || busy) bad++;
    end
    check("abort in H1 no exhausted", bad, 0);
    check("abort in H1 no launch", start_cnt - s0, 0);
    check("abort in H1 hashes_done", hashes_done, 0);

    // Randomized jobs against the reference model
    for (int i = 0; i < 10; i++) begin
      mid = rand256(); tail = rand256(); tgt = rand256();
      s = (i % 3 == 0) ? 32'hFFFFFFFF - $urandom_range(0, 3) : $urandom();
      e = s + $urandom_range(0, 5);
      if (e < s) e = 32'hFFFFFFFF;
      run_job(mid, tail, tgt, s, e, $urandom_range(1, 6), $sformatf("rnd%0d", i),
              nf, nx, hs, st, ac, ef, eh);
      check($sformatf("rnd%0d found count", i), nf, ef);
      check($sformatf("rnd%0d hashes_done", i), hs, eh);
      check($sformatf("rnd%0d core_start count", i), st, 2 * eh);
      check($sformatf("rnd%0d exhausted pulses", i), nx, 1);
    end

    check("core_start while core outstanding", overlap_viol, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
